// File: rtl/com_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : com_fifo_ctrl
// Purpose  : Memory-mapped serial port controller with parametrised RX/TX
//            FIFOs, interrupt generation and sticky overflow flags. It sits
//            between the COM register window and the async receiver/
//            transmitter pair.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RX_DEPTH_LOG2 : log2 of RX FIFO depth (1..7)
//   TX_DEPTH_LOG2 : log2 of TX FIFO depth (1..7)
// Ports
//   clk          in   system clock (25 MHz)
//   rst_n        in   asynchronous active-low reset
//   enable_i     in   access strobe, one cycle = one access
//   readEnable_i in   1 = read, 0 = write
//   mode_i       in   register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//   dataSave_i   in   write data
//   dataLoad_o   out  read data (combinational)
//   int_o        out  COM interrupt (level)
//   rxdReady_i   in   receiver byte-valid pulse
//   rxdData_i    in   received byte
//   txdBusy_i    in   transmitter busy
//   txdStart_o   out  one-cycle transmitter start pulse
//   txdData_o    out  byte to transmit (registered)
// Build option
//   COM_LOOPBACK_EN : adds CTRL[2] loopback, routing TX bytes into the RX FIFO
// ============================================================================
module com_fifo_ctrl #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic [1:0]  mode_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);

  localparam int c_RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int c_TX_DEPTH = 1 << TX_DEPTH_LOG2;

  localparam logic [RX_DEPTH_LOG2:0]   c_RX_FULL    = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
  localparam logic [TX_DEPTH_LOG2:0]   c_TX_FULL    = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2-1:0] c_RX_PTR_ONE = 1;
  localparam logic [TX_DEPTH_LOG2-1:0] c_TX_PTR_ONE = 1;
  localparam logic [RX_DEPTH_LOG2:0]   c_RX_CNT_ONE = 1;
  localparam logic [TX_DEPTH_LOG2:0]   c_TX_CNT_ONE = 1;

  localparam logic [1:0] c_MODE_DATA   = 2'd0;
  localparam logic [1:0] c_MODE_STATUS = 2'd1;
  localparam logic [1:0] c_MODE_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } tx_state_t;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [7:0]               r_rx_mem [c_RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] r_rx_wptr;
  logic [RX_DEPTH_LOG2-1:0] r_rx_rptr;
  logic [RX_DEPTH_LOG2:0]   r_rx_count;

  logic [7:0]               r_tx_mem [c_TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] r_tx_wptr;
  logic [TX_DEPTH_LOG2-1:0] r_tx_rptr;
  logic [TX_DEPTH_LOG2:0]   r_tx_count;

  logic       r_rx_ovf;
  logic       r_tx_ovf;
  logic       r_rx_int_en;
  logic       r_tx_int_en;
  logic [7:0] r_rx_thresh;
  logic [7:0] r_txd_data;

  tx_state_t  r_state;
  tx_state_t  w_state_next;

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  logic w_rd;
  logic w_wr;
  logic w_data_rd;
  logic w_data_wr;
  logic w_status_rd;
  logic w_ctrl_wr;

  assign w_rd        = enable_i &  readEnable_i;
  assign w_wr        = enable_i & ~readEnable_i;
  assign w_data_rd   = w_rd & (mode_i == c_MODE_DATA);
  assign w_data_wr   = w_wr & (mode_i == c_MODE_DATA);
  assign w_status_rd = w_rd & (mode_i == c_MODE_STATUS);
  assign w_ctrl_wr   = w_wr & (mode_i == c_MODE_CTRL);

  // Upper write-data bits have no register behind them.
  logic w_unused_wdata;
  assign w_unused_wdata = ^dataSave_i[31:16];

  logic w_rx_empty;
  logic w_rx_full;
  logic w_tx_empty;
  logic w_tx_full;

  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_full  = (r_rx_count == c_RX_FULL);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == c_TX_FULL);

  // --------------------------------------------------------------------------
  // Loopback option
  // --------------------------------------------------------------------------
  logic       w_loopback;
  logic       w_rx_push_req;
  logic [7:0] w_rx_push_data;
  logic       w_tx_pop;

  assign w_tx_pop = (r_state == ST_START);

`ifdef COM_LOOPBACK_EN
  logic r_loopback;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loopback <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_loopback <= dataSave_i[2];
    end
  end

  assign w_loopback = r_loopback;

  // In loopback the byte popped by START (already latched in r_txd_data on
  // entry) is fed back into RX; receiver pulses are discarded entirely.
  assign w_rx_push_req  = r_loopback ? w_tx_pop   : rxdReady_i;
  assign w_rx_push_data = r_loopback ? r_txd_data : rxdData_i;
`else
  assign w_loopback     = 1'b0;
  assign w_rx_push_req  = rxdReady_i;
  assign w_rx_push_data = rxdData_i;
`endif

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic w_rx_pop;
  logic w_rx_push;
  logic w_rx_ovf_set;

  assign w_rx_pop     = w_data_rd & ~w_rx_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign w_rx_push    = w_rx_push_req & (~w_rx_full | w_rx_pop);
  assign w_rx_ovf_set = w_rx_push_req &   w_rx_full & ~w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr] <= w_rx_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_wptr <= r_rx_wptr + c_RX_PTR_ONE;
      end
      if (w_rx_pop) begin
        r_rx_rptr <= r_rx_rptr + c_RX_PTR_ONE;
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + c_RX_CNT_ONE;
        2'b01:   r_rx_count <= r_rx_count - c_RX_CNT_ONE;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic w_tx_push;
  logic w_tx_ovf_set;

  assign w_tx_push    = w_data_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set = w_data_wr &   w_tx_full & ~w_tx_pop;

  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr] <= dataSave_i[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wptr <= r_tx_wptr + c_TX_PTR_ONE;
      end
      if (w_tx_pop) begin
        r_tx_rptr <= r_tx_rptr + c_TX_PTR_ONE;
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + c_TX_CNT_ONE;
        2'b01:   r_tx_count <= r_tx_count - c_TX_CNT_ONE;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags and control register
  // --------------------------------------------------------------------------
  // A STATUS read clears the flags, but an overflow in that same cycle wins
  // so that the event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_status_rd) begin
        r_rx_ovf <= 1'b0;
        r_tx_ovf <= 1'b0;
      end
      if (w_rx_ovf_set) begin
        r_rx_ovf <= 1'b1;
      end
      if (w_tx_ovf_set) begin
        r_tx_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_int_en <= 1'b1;
      r_tx_int_en <= 1'b0;
      r_rx_thresh <= 8'd1;
    end else if (w_ctrl_wr) begin
      r_rx_int_en <= dataSave_i[0];
      r_tx_int_en <= dataSave_i[1];
      r_rx_thresh <= dataSave_i[15:8];
    end
  end

  // --------------------------------------------------------------------------
  // TX sequencer
  // --------------------------------------------------------------------------
  logic w_tx_load;

  always_comb begin
    w_state_next = r_state;
    w_tx_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_tx_empty && (!txdBusy_i || w_loopback)) begin
          w_state_next = ST_START;
          w_tx_load    = 1'b1;
        end
      end
      ST_START: w_state_next = ST_WAIT;
      // One cycle of dead time covers the transmitter's busy-assert latency.
      ST_WAIT:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_txd_data <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_tx_load) begin
        r_txd_data <= r_tx_mem[r_tx_rptr];
      end
    end
  end

  assign txdStart_o = w_tx_pop & ~w_loopback;
  assign txdData_o  = r_txd_data;

  // --------------------------------------------------------------------------
  // Interrupt
  // --------------------------------------------------------------------------
  logic [7:0] w_rx_cnt8;
  logic [7:0] w_tx_cnt8;
  logic [7:0] w_rx_thr_eff;
  logic       w_rx_irq;
  logic       w_tx_irq;

  assign w_rx_cnt8    = 8'(r_rx_count);
  assign w_tx_cnt8    = 8'(r_tx_count);
  // A threshold of 0 behaves as 1; thresholds above depth can never be met.
  assign w_rx_thr_eff = (r_rx_thresh == 8'd0) ? 8'd1 : r_rx_thresh;
  assign w_rx_irq     = r_rx_int_en & (w_rx_cnt8 >= w_rx_thr_eff);
  assign w_tx_irq     = r_tx_int_en & w_tx_empty & (r_state == ST_IDLE);
  assign int_o        = w_rx_irq | w_tx_irq;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    dataLoad_o = 32'h0000_0000;
    if (w_rd) begin
      case (mode_i)
        c_MODE_DATA: begin
          if (!w_rx_empty) begin
            dataLoad_o = {24'h00_0000, r_rx_mem[r_rx_rptr]};
          end
        end
        c_MODE_STATUS: begin
          dataLoad_o = {8'h00, w_tx_cnt8, w_rx_cnt8, 4'h0,
                        r_tx_ovf, r_rx_ovf, ~w_rx_empty, ~w_tx_full};
        end
        c_MODE_CTRL: begin
          dataLoad_o = {16'h0000, r_rx_thresh, 5'h00,
                        w_loopback, r_tx_int_en, r_rx_int_en};
        end
        default: dataLoad_o = 32'h0000_0000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_com_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_com_fifo_ctrl
// Purpose  : Self-checking bench for com_fifo_ctrl. A queue-based model of the
//            register map, FIFOs and TX start timing predicts every output on
//            every cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_com_fifo_ctrl;

  localparam int RXL = 4;
  localparam int TXL = 4;
  localparam int RXD = 1 << RXL;
  localparam int TXD = 1 << TXL;
`ifdef COM_LOOPBACK_EN
  localparam bit LB_BUILD = 1'b1;
`else
  localparam bit LB_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        readEnable_i;
  logic [1:0]  mode_i;
  logic [31:0] dataSave_i;
  logic [31:0] dataLoad_o;
  logic        int_o;
  logic        rxdReady_i;
  logic [7:0]  rxdData_i;
  logic        txdBusy_i;
  logic        txdStart_o;
  logic [7:0]  txdData_o;

  always #20 clk = ~clk;

  com_fifo_ctrl #(.RX_DEPTH_LOG2(RXL), .TX_DEPTH_LOG2(TXL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .readEnable_i (readEnable_i),
    .mode_i       (mode_i),
    .dataSave_i   (dataSave_i),
    .dataLoad_o   (dataLoad_o),
    .int_o        (int_o),
    .rxdReady_i   (rxdReady_i),
    .rxdData_i    (rxdData_i),
    .txdBusy_i    (txdBusy_i),
    .txdStart_o   (txdStart_o),
    .txdData_o    (txdData_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit         m_rx_ovf, m_tx_ovf, m_rx_ie, m_tx_ie, m_lb;
  logic [7:0] m_thresh;
  logic [7:0] m_txd;
  int         cyc;
  int         last_start;

  // Bench-side transmitter and observations
  int         busy_cnt;
  int         busy_len = 20;
  int         n_starts;
  logic [7:0] start_bytes[$];
  logic [31:0] obs_load;
  logic        obs_int;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_rx_ovf = 0; m_tx_ovf = 0;
    m_rx_ie = 1; m_tx_ie = 0; m_lb = 0;
    m_thresh = 8'd1;
    m_txd = 8'h00;
    cyc = 0;
    last_start = -100;
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable_i = 0; readEnable_i = 0; mode_i = 0; dataSave_i = 0;
    rxdReady_i = 0; rxdData_i = 0; txdBusy_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model across the coming rising edge.
  task automatic step(input bit en, input bit rd, input logic [1:0] md,
                      input logic [31:0] d, input bit rxr, input logic [7:0] rxd);
    logic [31:0] e_load;
    bit          e_int, s_now, idle, start_next, busy, rx_pop, rx_req, full_pre;
    logic [7:0]  rx_byte, popped;
    int          thr;
    @(negedge clk);
    enable_i = en; readEnable_i = rd; mode_i = md; dataSave_i = d;
    rxdReady_i = rxr; rxdData_i = rxd;
    busy = (busy_cnt > 0);
    txdBusy_i = busy;
    #1;
    s_now = (cyc == last_start);
    idle  = (cyc - last_start >= 2);
    thr   = (m_thresh == 0) ? 1 : int'(m_thresh);

    e_load = 32'h0;
    if (en && rd) begin
      case (md)
        2'd0: if (rxq.size() > 0) e_load = {24'h0, rxq[0]};
        2'd1: e_load = {8'h0, 8'(txq.size()), 8'(rxq.size()), 4'h0,
                        m_tx_ovf, m_rx_ovf, rxq.size() != 0, txq.size() != TXD};
        2'd2: e_load = {16'h0, m_thresh, 5'h0, m_lb, m_tx_ie, m_rx_ie};
        default: e_load = 32'h0;
      endcase
    end
    e_int = (m_rx_ie && rxq.size() >= thr) || (m_tx_ie && txq.size() == 0 && idle);

    chk("dataLoad", dataLoad_o, e_load);
    chk("int", {31'h0, int_o}, {31'h0, e_int});
    chk("txdStart", {31'h0, txdStart_o}, {31'h0, s_now && !m_lb});
    chk("txdData", {24'h0, txdData_o}, {24'h0, m_txd});
    obs_load = dataLoad_o;
    obs_int  = int_o;
    if (txdStart_o) begin
      n_starts++;
      start_bytes.push_back(txdData_o);
    end

    // ---- model update (all decisions from pre-edge values) ----
    start_next = idle && txq.size() > 0 && (!busy || m_lb);
    if (start_next) m_txd = txq[0];
    popped = (txq.size() > 0) ? txq[0] : 8'h00;

    if (en && rd && md == 2'd1) begin
      m_rx_ovf = 0;
      m_tx_ovf = 0;
    end

    rx_pop  = en && rd && md == 2'd0 && rxq.size() > 0;
    rx_req  = m_lb ? s_now : rxr;
    rx_byte = m_lb ? popped : rxd;
    full_pre = (rxq.size() == RXD);
    if (rx_pop) void'(rxq.pop_front());
    if (rx_req) begin
      if (!full_pre || rx_pop) rxq.push_back(rx_byte);
      else m_rx_ovf = 1;
    end

    full_pre = (txq.size() == TXD);
    if (s_now) void'(txq.pop_front());
    if (en && !rd && md == 2'd0) begin
      if (!full_pre || s_now) txq.push_back(d[7:0]);
      else m_tx_ovf = 1;
    end

    if (en && !rd && md == 2'd2) begin
      m_rx_ie  = d[0];
      m_tx_ie  = d[1];
      m_thresh = d[15:8];
      if (LB_BUILD) m_lb = d[2];
    end

    if (start_next) last_start = cyc + 1;
    cyc++;

    // Transmitter: busy for busy_len cycles starting the cycle after a start.
    if (s_now && !m_lb) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(0, 0, 2'd0, 32'h0, 0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] md, input logic [31:0] d);
    step(1, 0, md, d, 0, 8'h00);
  endtask

  task automatic rdr(input logic [1:0] md);
    step(1, 1, md, 32'h0, 0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b1;
    model_reset();
    do_reset();

    // Reset state
    rdr(2'd1);
    chk("reset_status", obs_load, 32'h0000_0001);
    chk("reset_int", {31'h0, obs_int}, 32'h0);
    rdr(2'd2);
    chk("reset_ctrl", obs_load, 32'h0000_0101);

    // Two TX bytes with a 20-cycle busy transmitter
    busy_len = 20;
    n_starts = 0;
    start_bytes.delete();
    wr(2'd0, 32'h41);
    wr(2'd0, 32'h42);
    idle_cycles(70);
    chk("tx_starts", n_starts, 2);
    if (start_bytes.size() == 2) begin
      chk("tx_byte0", {24'h0, start_bytes[0]}, 32'h41);
      chk("tx_byte1", {24'h0, start_bytes[1]}, 32'h42);
    end
    rdr(2'd1);
    chk("tx_count_zero", {24'h0, obs_load[23:16]}, 32'h0);

    // RX overflow and drain
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 0, 2'd0, 32'h0, 1, 8'(i));
    rdr(2'd1);
    chk("rx_full_status", obs_load, 32'h0000_1007);
    rdr(2'd1);
    chk("rx_ovf_cleared", obs_load, 32'h0000_1003);
    for (int i = 0; i < 16; i++) begin
      rdr(2'd0);
      chk("rx_drain", obs_load, 32'(i));
    end
    rdr(2'd0);
    chk("rx_empty_read", obs_load, 32'h0);

    // Interrupt thresholds
    do_reset();
    busy_len = 20;
    wr(2'd2, 32'h0000_0403);
    idle_cycles(1);
    chk("int_tx_idle", {31'h0, obs_int}, 32'h1);
    wr(2'd0, 32'h77);
    idle_cycles(1);
    chk("int_tx_pending", {31'h0, obs_int}, 32'h0);
    idle_cycles(2);
    chk("int_tx_wait", {31'h0, obs_int}, 32'h0);
    idle_cycles(1);
    chk("int_tx_done", {31'h0, obs_int}, 32'h1);
    wr(2'd2, 32'h0000_0401);
    for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 32'h0, 1, 8'(8'h60 + i));
    idle_cycles(1);
    chk("int_rx_below", {31'h0, obs_int}, 32'h0);
    step(0, 0, 2'd0, 32'h0, 1, 8'h63);
    idle_cycles(1);
    chk("int_rx_at", {31'h0, obs_int}, 32'h1);

    // Push and pop together while RX is full
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 2'd0, 32'h0, 1, 8'(8'h20 + i));
    step(1, 1, 2'd0, 32'h0, 1, 8'hAA);
    chk("full_pushpop_head", obs_load, 32'h20);
    rdr(2'd1);
    chk("full_pushpop_status", obs_load, 32'h0000_1003);
    rdr(2'd0);
    chk("full_pushpop_next", obs_load, 32'h21);

`ifdef COM_LOOPBACK_EN
    // Loopback
    do_reset();
    n_starts = 0;
    wr(2'd2, 32'h0000_0105);
    wr(2'd0, 32'h5A);
    idle_cycles(6);
    chk("lb_no_start", n_starts, 0);
    rdr(2'd1);
    chk("lb_rx_count", {24'h0, obs_load[15:8]}, 32'h1);
    rdr(2'd0);
    chk("lb_data", obs_load, 32'h5A);
`endif

    // Randomized traffic, rx/read balance varies per block
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      int rx_pct;
      int rd_pct;
      rx_pct = (blk % 2 == 0) ? 45 : 10;
      rd_pct = (blk % 2 == 0) ? 20 : 60;
      for (int i = 0; i < 500; i++) begin
        bit en, rd, rxr;
        logic [1:0] md;
        logic [31:0] d;
        int r;
        busy_len = $urandom_range(0, 8);
        en  = ($urandom_range(0, 99) < 45);
        rd  = ($urandom_range(0, 99) < rd_pct + 20);
        r   = $urandom_range(0, 99);
        md  = (r < 55) ? 2'd0 : (r < 75) ? 2'd1 : (r < 92) ? 2'd2 : 2'd3;
        d   = $urandom;
        if (md == 2'd2 && !rd) d[15:8] = 8'($urandom_range(0, 20));
        rxr = ($urandom_range(0, 99) < rx_pct);
        step(en, rd, md, d, rxr, 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
